// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: Moore datapath controls, memory handshake with a
// bounded wait watchdog, illegal-opcode trap and retired-instruction counter.
module mc_ctrl_fsm #(
  parameter int unsigned MAX_WAIT  = 16,
  parameter int unsigned WAIT_W    = 5,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned HANDSHAKE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             IorD,
  output logic             IRwrite,
  output logic             pc_en,
  output logic             RegWrite,
  output logic             reg_dst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             halted,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_ERR    = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [3:0]        state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        next_err;
  logic              ready_eff, wait_hit, pc_write, branch, branch_ne, retire;

  // Qualifying ready with reset keeps IR/PC loads dead while reset is held.
  assign ready_eff = reset & ((HANDSHAKE != 0) ? mem_ready : 1'b1);
  assign wait_hit  = ~ready_eff && (wait_cnt == WAIT_LAST);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    next_err   = err_code;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    IorD       = 1'b0;
    IRwrite    = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    RegWrite   = 1'b0;
    reg_dst    = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    halted     = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (ready_eff) begin
          IRwrite    = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (wait_hit) begin
          next_state = S_ERR;
          next_err   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        unique case (opcode)
          OP_LW, OP_SW:    next_state = S_MEMADR;
          OP_R:            next_state = S_EXEC;
          OP_BEQ, OP_BNE:  next_state = S_BRANCH;
          OP_ADDI:         next_state = S_ADDIEX;
          OP_J:            next_state = S_JUMP;
          default: begin
            next_state = S_ERR;
            next_err   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD, S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = (state == S_MEMWR);
        IorD      = 1'b1;
        if (ready_eff) begin
          next_state = (state == S_MEMWR) ? S_FETCH : S_MEMWB;
        end else if (wait_hit) begin
          next_state = S_ERR;
          next_err   = ERR_TIMEOUT;
        end
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        memtoreg   = 1'b1;
        next_state = S_FETCH;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        ALUOp      = 2'b10;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        ALUOp      = 2'b01;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        branch_ne  = (opcode == OP_BNE);
        next_state = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pc_write   = 1'b1;
        next_state = S_FETCH;
      end
      S_ERR: halted = 1'b1;
      default: next_state = S_FETCH;
    endcase
  end

  assign pc_en  = pc_write | (branch & (zero ^ branch_ne));
  assign retire = (next_state == S_FETCH) && (state != S_FETCH) && (state != S_ERR);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      err_code <= ERR_NONE;
      retired  <= '0;
    end else begin
      state    <= next_state;
      err_code <= next_err;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (mem_req && !ready_eff) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: one handshaking instance (MAX_WAIT=4, CNT_W=2)
// plus a HANDSHAKE=0 instance sharing the same inputs.
module tb_mc_ctrl_fsm;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;

  logic       mem_req, mem_write, IorD, IRwrite, pc_en, RegWrite, reg_dst, memtoreg, alusrca, halted;
  logic [1:0] alusrcb, ALUOp, PCSrc, err_code, retired;

  logic       nh_mem_req, nh_mem_write, nh_IorD, nh_IRwrite, nh_pc_en, nh_RegWrite, nh_reg_dst;
  logic       nh_memtoreg, nh_alusrca, nh_halted;
  logic [1:0] nh_alusrcb, nh_ALUOp, nh_PCSrc, nh_err_code, nh_retired;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MAX_WAIT(4), .WAIT_W(3), .CNT_W(2), .HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .IorD(IorD), .IRwrite(IRwrite),
    .pc_en(pc_en), .RegWrite(RegWrite), .reg_dst(reg_dst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .halted(halted), .err_code(err_code), .retired(retired)
  );

  mc_ctrl_fsm #(.MAX_WAIT(4), .WAIT_W(3), .CNT_W(2), .HANDSHAKE(0)) dut_nh (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(nh_mem_req), .mem_write(nh_mem_write), .IorD(nh_IorD), .IRwrite(nh_IRwrite),
    .pc_en(nh_pc_en), .RegWrite(nh_RegWrite), .reg_dst(nh_reg_dst), .memtoreg(nh_memtoreg),
    .alusrca(nh_alusrca), .alusrcb(nh_alusrcb), .ALUOp(nh_ALUOp), .PCSrc(nh_PCSrc),
    .halted(nh_halted), .err_code(nh_err_code), .retired(nh_retired)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic rdy, input logic z);
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    #1;
  endtask

  initial begin
    reset = 1'b0; opcode = OP_LW; mem_ready = 1'b0; zero = 1'b0;
    #12;
    check("rst_mem_req", 32'(mem_req), 1);
    check("rst_irwrite", 32'(IRwrite), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_err_code", 32'(err_code), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_alusrcb", 32'(alusrcb), 1);
    mem_ready = 1'b1; #1;
    check("rst_pc_en_ready", 32'(pc_en), 0);
    check("rst_irwrite_ready", 32'(IRwrite), 0);
    @(posedge clk); #1;
    reset = 1'b1; #1;

    // lw, zero-wait: FETCH DECODE MEMADR MEMRD MEMWB
    check("lw_fetch_irwrite", 32'(IRwrite), 1);
    check("lw_fetch_pc_en", 32'(pc_en), 1);
    check("lw_fetch_iord", 32'(IorD), 0);
    tick();
    check("lw_dec_alusrcb", 32'(alusrcb), 3);
    check("lw_dec_mem_req", 32'(mem_req), 0);
    tick();
    check("lw_adr_alusrca", 32'(alusrca), 1);
    check("lw_adr_alusrcb", 32'(alusrcb), 2);
    tick();
    check("lw_rd_mem_req", 32'(mem_req), 1);
    check("lw_rd_iord", 32'(IorD), 1);
    check("lw_rd_mem_write", 32'(mem_write), 0);
    check("lw_rd_regwrite", 32'(RegWrite), 0);
    tick();
    check("lw_wb_regwrite", 32'(RegWrite), 1);
    check("lw_wb_reg_dst", 32'(reg_dst), 0);
    check("lw_wb_memtoreg", 32'(memtoreg), 1);
    tick();
    check("lw_retired", 32'(retired), 1);
    check("lw_back_fetch", 32'(mem_req), 1);

    // beq taken, bne not taken with zero=1
    drive(OP_BEQ, 1'b1, 1'b1);
    tick(); tick();
    check("beq_pc_en", 32'(pc_en), 1);
    check("beq_pcsrc", 32'(PCSrc), 1);
    check("beq_aluop", 32'(ALUOp), 1);
    tick();
    check("beq_retired", 32'(retired), 2);
    drive(OP_BNE, 1'b1, 1'b1);
    tick(); tick();
    check("bne_pc_en", 32'(pc_en), 0);
    check("bne_pcsrc", 32'(PCSrc), 1);
    tick();
    check("bne_retired", 32'(retired), 3);

    // sw with 3 not-ready cycles in MEMWR: 7 cycles, no trap, retired wraps to 0
    drive(OP_SW, 1'b1, 1'b0);
    tick(); tick(); tick();
    drive(OP_SW, 1'b0, 1'b0);
    check("sw_wr0_mem_write", 32'(mem_write), 1);
    tick();
    check("sw_wr1_mem_write", 32'(mem_write), 1);
    tick();
    check("sw_wr2_mem_write", 32'(mem_write), 1);
    tick();
    drive(OP_SW, 1'b1, 1'b0);
    check("sw_wr3_mem_write", 32'(mem_write), 1);
    check("sw_wr3_halted", 32'(halted), 0);
    tick();
    check("sw_retired_wrap", 32'(retired), 0);
    check("sw_done_mem_write", 32'(mem_write), 0);
    check("sw_done_fetch_iord", 32'(IorD), 0);

    // addi and j
    drive(OP_ADDI, 1'b1, 1'b0);
    tick(); tick();
    check("addiex_alusrcb", 32'(alusrcb), 2);
    check("addiex_regwrite", 32'(RegWrite), 0);
    tick();
    check("addiwb_regwrite", 32'(RegWrite), 1);
    check("addiwb_reg_dst", 32'(reg_dst), 0);
    check("addiwb_memtoreg", 32'(memtoreg), 0);
    tick();
    check("addi_retired", 32'(retired), 1);
    drive(OP_J, 1'b1, 1'b0);
    tick(); tick();
    check("j_pcsrc", 32'(PCSrc), 2);
    check("j_pc_en", 32'(pc_en), 1);
    tick();
    check("j_retired", 32'(retired), 2);

    // reset pulse, then five R-types: retired 1,2,3,0,1
    reset = 1'b0; #1;
    check("pulse_retired", 32'(retired), 0);
    reset = 1'b1; opcode = OP_R; #1;
    for (int i = 0; i < 5; i++) begin
      tick(); tick();
      check($sformatf("r%0d_exec_aluop", i), 32'(ALUOp), 2);
      tick();
      check($sformatf("r%0d_wb_reg_dst", i), 32'(reg_dst), 1);
      tick();
      check($sformatf("r%0d_retired", i), 32'(retired), 32'((i + 1) % 4));
    end

    // illegal opcode traps from DECODE
    drive(OP_BAD, 1'b1, 1'b0);
    tick(); tick();
    check("ill_halted", 32'(halted), 1);
    check("ill_err_code", 32'(err_code), 1);
    check("ill_mem_req", 32'(mem_req), 0);
    check("ill_pc_en", 32'(pc_en), 0);
    tick(); tick();
    check("ill_held", 32'(halted), 1);
    check("ill_irwrite", 32'(IRwrite), 0);
    reset = 1'b0; #1;
    check("clr_halted", 32'(halted), 0);
    check("clr_err_code", 32'(err_code), 0);
    check("clr_retired", 32'(retired), 0);
    check("clr_mem_req", 32'(mem_req), 1);

    // watchdog: mem_ready stuck 0 in FETCH traps after 4 wait cycles
    opcode = OP_R; mem_ready = 1'b0; reset = 1'b1; #1;
    check("wd_irwrite_c0", 32'(IRwrite), 0);
    check("nh_irwrite_no_ready", 32'(nh_IRwrite), 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("wd_c%0d_irwrite", i), 32'(IRwrite), 0);
      check($sformatf("wd_c%0d_halted", i), 32'(halted), 0);
    end
    tick();
    check("wd_halted", 32'(halted), 1);
    check("wd_err_code", 32'(err_code), 2);
    check("wd_irwrite", 32'(IRwrite), 0);
    check("wd_mem_req", 32'(mem_req), 0);
    check("nh_retired", 32'(nh_retired), 1);
    check("nh_halted", 32'(nh_halted), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
